nor_truth_table_sweeper: RTL and testbench
==========================================

Name: nor_truth_table_sweeper

Overview:
Self-checking driver and capture stage for the week-3 4-input NOR-only logic block, f = b'd' + b'c' + a'c'd'.
- Upstream role: on a start pulse, drives a,b,c,d through all 16 input combinations.
- Downstream role: samples the block's f output, builds the captured 16-bit truth table, compares it bit-by-bit against an expected mask, and reports mismatch count, first failing minterm and pass/fail.
- Lets the combinational lab block be exercised on the board or in simulation without hand-toggling switches.

Parameters:
EXPECTED, 16'h0717, golden truth table; bit i = expected f for {a,b,c,d} = i (a is MSB). Minterms 0,1,2,4,8,9,10.
LAT, 0, cycles between a vector being driven and its f being valid at f_in (0..3).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin a sweep
f_in  input  1  f from the logic block under test
a  output  1  vector bit 3 (MSB)
b  output  1  vector bit 2
c  output  1  vector bit 1
d  output  1  vector bit 0
vec_valid  output  1  high while a,b,c,d carry a sweep vector
busy  output  1  sweep or drain in progress
done  output  1  results valid; held until next start or reset
pass  output  1  done and err_cnt == 0
table_out  output  16  captured f per minterm
err_cnt  output  5  mismatches in the last sweep (0..16)
first_err_idx  output  4  lowest-order (first captured) failing minterm
first_err_valid  output  1  at least one mismatch recorded

Behaviour:
- All outputs are registered. On rst (sync, any state) the block goes to IDLE and every output is cleared to 0: a,b,c,d, vec_valid, busy, done, pass, table_out, err_cnt, first_err_idx, first_err_valid. The capture pipeline is flushed.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 -> SWEEP.
  - Clear table_out, err_cnt, first_err_* on that edge.
  - Set idx=0, busy=1.
- SWEEP: each cycle presents {a,b,c,d}=idx with vec_valid=1, then idx increments.
  - Vector idx 15 is the last. After it: -> DRAIN if LAT>0, else -> DONE.
  - vec_valid and a..d return to 0 on leaving SWEEP.
- DRAIN: waits exactly LAT cycles for the pipeline to empty, then -> DONE.
- DONE: done=1, busy=0, pass=(err_cnt==0).
  - start=1 -> clears results and re-enters SWEEP exactly as from IDLE.
- Capture: a valid-tagged shift pipe of depth LAT carries the idx of each driven vector.
  - At the edge where the tag emerges, f_in is written to table_out[tag].
  - If f_in != EXPECTED[tag]: err_cnt += 1. If first_err_valid==0, also set first_err_idx=tag and first_err_valid=1.
  - With LAT=0, f_in is sampled at the same edge that ends the vector's cycle (the combinational block settles within the cycle).
- Timing (LAT=0): start sampled at edge E0; vectors 0..15 are presented in cycles 1..16; done rises after edge E17. In general done rises at E(17+LAT). busy is high from E1 until done rises.
- start while busy is ignored: no restart, no result change. start in the same cycle as rst: rst wins.
- err_cnt saturates naturally at 16 (5 bits; it cannot exceed 16).
- idx is 4 bits and does not wrap inside a sweep: the SWEEP exit is decoded from idx==15.
- Reset mid-sweep aborts immediately and discards partial results. The next start begins from idx 0.

Test Plan:
1. Reset, then start with f_in driven by a correct model of the NOR block, LAT=0 -> 16 vectors 0..15 in order; done at E17; table_out=16'h0717, err_cnt=0, pass=1, first_err_valid=0.
2. f_in tied 0 -> table_out=16'h0000, err_cnt=7, first_err_idx=0, first_err_valid=1, pass=0.
3. f_in tied 1 -> table_out=16'hFFFF, err_cnt=9, first_err_idx=3, pass=0. Then start again with the correct model -> results cleared, pass=1.
4. Correct model delayed by two registers, LAT=2 -> done at E19, table_out=16'h0717, pass=1. Same stimulus with LAT=0 -> err_cnt nonzero.
5. start pulsed at vector 5 mid-sweep -> ignored; the sweep completes normally with a single done. rst asserted at vector 8 -> next cycle all outputs 0, FSM in IDLE; a new start gives a full 0..15 sweep.
6. Inverted model (f_in = ~f) -> table_out=16'hF8E8, err_cnt=16, first_err_idx=0, pass=0.

Source files
------------

// File: rtl/nor_truth_table_sweeper_if.sv
// Bus between the NOR truth-table sweeper and whatever drives start / observes results.
// The slave side is the sweeper; the master side supplies start and the block's f output.
interface nor_truth_table_sweeper_if;
    logic        start;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        vec_valid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err_idx;
    logic        first_err_valid;

    modport master (
        output start, f_in,
        input  a, b, c, d, vec_valid, busy, done, pass,
        input  table_out, err_cnt, first_err_idx, first_err_valid
    );

    modport slave (
        input  start, f_in,
        output a, b, c, d, vec_valid, busy, done, pass,
        output table_out, err_cnt, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/nor_truth_table_sweeper.sv
// Drives all 16 {a,b,c,d} vectors into the NOR lab block and grades the captured
// truth table against EXPECTED (mismatch count, first failing minterm, pass).
//
// state | meaning
// IDLE  | waiting for start after reset
// SWEEP | presenting vectors 0..15, one per cycle
// DRAIN | waiting LAT cycles for the last samples to come back
// DONE  | results valid and held until the next start
module nor_truth_table_sweeper #(
    parameter logic [15:0] EXPECTED = 16'h0717,
    parameter int          LAT      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    nor_truth_table_sweeper_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam logic [1:0] DRAIN_LOAD = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

    state_t     state;
    logic [3:0] idx;
    logic       last_sent;
    logic [1:0] drain_cnt;
    logic [3:0] vec;
    logic       cap_valid;
    logic [3:0] cap_tag;
    logic       cap_err;
    logic [4:0] err_cnt_nxt;

    assign vec = {bus.a, bus.b, bus.c, bus.d};

    // The tag travelling with each vector emerges exactly when its f is valid.
    generate
        if (LAT == 0) begin : g_no_pipe
            assign cap_valid = bus.vec_valid;
            assign cap_tag   = vec;
        end else begin : g_pipe
            logic [4:0] pipe [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= {bus.vec_valid, vec};
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign cap_valid = pipe[LAT-1][4];
            assign cap_tag   = pipe[LAT-1][3:0];
        end
    endgenerate

    always_comb begin
        cap_err     = cap_valid && (bus.f_in != EXPECTED[cap_tag]);
        err_cnt_nxt = bus.err_cnt + {4'd0, cap_err};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            idx                 <= '0;
            last_sent           <= 1'b0;
            drain_cnt           <= '0;
            bus.a               <= 1'b0;
            bus.b               <= 1'b0;
            bus.c               <= 1'b0;
            bus.d               <= 1'b0;
            bus.vec_valid       <= 1'b0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.pass            <= 1'b0;
            bus.table_out       <= '0;
            bus.err_cnt         <= '0;
            bus.first_err_idx   <= '0;
            bus.first_err_valid <= 1'b0;
        end else begin
            if (cap_valid) begin
                bus.table_out[cap_tag] <= bus.f_in;
                if (cap_err) begin
                    bus.err_cnt <= err_cnt_nxt;
                    if (!bus.first_err_valid) begin
                        bus.first_err_idx   <= cap_tag;
                        bus.first_err_valid <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state               <= SWEEP;
                        idx                 <= '0;
                        last_sent           <= 1'b0;
                        bus.busy            <= 1'b1;
                        bus.done            <= 1'b0;
                        bus.pass            <= 1'b0;
                        bus.table_out       <= '0;
                        bus.err_cnt         <= '0;
                        bus.first_err_idx   <= '0;
                        bus.first_err_valid <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (last_sent) begin
                        bus.vec_valid                  <= 1'b0;
                        {bus.a, bus.b, bus.c, bus.d}   <= 4'd0;
                        if (LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= (err_cnt_nxt == 5'd0);
                        end
                    end else begin
                        {bus.a, bus.b, bus.c, bus.d} <= idx;
                        bus.vec_valid                <= 1'b1;
                        // idx parks at 15; last_sent marks the final vector instead of a wrap.
                        if (idx == 4'd15) last_sent <= 1'b1;
                        else              idx       <= idx + 4'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (err_cnt_nxt == 5'd0);
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_truth_table_sweeper.sv
// Bench for nor_truth_table_sweeper: a LAT=0 instance fed by selectable f models and a
// LAT=2 instance fed by the correct block delayed two registers.
module tb_nor_truth_table_sweeper;

    localparam logic [15:0] GOLD = 16'h0717;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    nor_truth_table_sweeper_if bus0 ();
    nor_truth_table_sweeper_if bus2 ();

    nor_truth_table_sweeper #(.EXPECTED(GOLD), .LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    nor_truth_table_sweeper #(.EXPECTED(GOLD), .LAT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        int          mode;
        logic [15:0] tbl;
        logic [4:0]  err;
        logic [3:0]  fidx;
        logic        fval;
        logic        pass;
    } vec_t;

    // The lab block itself, from its sum-of-products description.
    function automatic logic nor_f(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (~b & ~d) | (~b & ~c) | (~a & ~c & ~d);
    endfunction

    // Grading of a captured table against the golden one.
    function automatic vec_t ref_model(input int mode, input logic [15:0] tbl);
        vec_t r;
        logic [15:0] diff;
        diff   = tbl ^ GOLD;
        r.mode = mode;
        r.tbl  = tbl;
        r.err  = 5'($countones(diff));
        r.fval = (diff != 16'd0);
        r.fidx = 4'd0;
        for (int i = 15; i >= 0; i--) if (diff[i]) r.fidx = 4'(i);
        r.pass = (diff == 16'd0);
        return r;
    endfunction

    int          mode = 0;
    logic [15:0] rand_tbl = 16'd0;
    logic [1:0]  dly0 = 2'b00;
    logic [1:0]  dly2 = 2'b00;
    logic        f0;
    logic [3:0]  vec0;
    logic [3:0]  vec2;

    assign vec0 = {bus0.a, bus0.b, bus0.c, bus0.d};
    assign vec2 = {bus2.a, bus2.b, bus2.c, bus2.d};

    always_comb begin
        f0 = 1'b0;
        case (mode)
            0: f0 = nor_f(vec0);
            1: f0 = 1'b0;
            2: f0 = 1'b1;
            3: f0 = ~nor_f(vec0);
            4: f0 = rand_tbl[vec0];
            5: f0 = dly0[1];
            default: f0 = 1'b0;
        endcase
    end

    assign bus0.start = start;
    assign bus2.start = start;
    assign bus0.f_in  = f0;
    assign bus2.f_in  = dly2[1];

    always @(posedge clk) begin
        dly0 <= {dly0[0], nor_f(vec0)};
        dly2 <= {dly2[0], nor_f(vec2)};
    end

    logic [3:0] vlog[$];
    always @(negedge clk) if (bus0.vec_valid) vlog.push_back(vec0);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int which);
        if (which == 0)
            return {30'd0, bus0.a, bus0.b, bus0.c, bus0.d, bus0.vec_valid, bus0.busy, bus0.done,
                    bus0.pass, bus0.table_out, bus0.err_cnt, bus0.first_err_idx, bus0.first_err_valid};
        return {30'd0, bus2.a, bus2.b, bus2.c, bus2.d, bus2.vec_valid, bus2.busy, bus2.done,
                bus2.pass, bus2.table_out, bus2.err_cnt, bus2.first_err_idx, bus2.first_err_valid};
    endfunction

    // Pulses start, then counts edges until each instance raises done (-1 if never).
    task automatic run_sweep(input int mid_at, output int n0, output int n2, output logic busy_e1);
        int n;
        bit inj;
        n0 = -1;
        n2 = -1;
        busy_e1 = 1'b0;
        inj = 1'b0;
        vlog.delete();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while ((n0 < 0 || n2 < 0) && n < 100) begin
            @(posedge clk);
            n++;
            #1 start = 1'b0;
            if (n == 1) busy_e1 = bus0.busy;
            if (bus0.done && n0 < 0) n0 = n;
            if (bus2.done && n2 < 0) n2 = n;
            if (mid_at >= 0 && !inj && bus0.vec_valid && vec0 == mid_at[3:0]) begin
                start = 1'b1;
                inj = 1'b1;
            end
        end
    endtask

    task automatic check_order(input string name);
        int ok;
        ok = (vlog.size() == 16);
        for (int i = 0; i < vlog.size(); i++) if (vlog[i] != 4'(i)) ok = 0;
        check(name, 64'(ok), 64'd1);
    endtask

    vec_t tv[8];
    int   n0, n2;
    logic be1;

    initial begin
        tv[0] = '{0, 16'h0717, 5'd0,  4'd0, 1'b0, 1'b1};
        tv[1] = '{1, 16'h0000, 5'd7,  4'd0, 1'b1, 1'b0};
        tv[2] = '{2, 16'hFFFF, 5'd9,  4'd3, 1'b1, 1'b0};
        tv[3] = '{0, 16'h0717, 5'd0,  4'd0, 1'b0, 1'b1};
        tv[4] = '{3, 16'hF8E8, 5'd16, 4'd0, 1'b1, 1'b0};
        for (int i = 5; i < 8; i++) tv[i] = ref_model(4, 16'($urandom));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_lat0", outs(0), 64'd0);
        check("reset_outputs_lat2", outs(2), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            mode = tv[i].mode;
            rand_tbl = tv[i].tbl;
            run_sweep(-1, n0, n2, be1);
            check($sformatf("v%0d_done_edge_lat0", i), 64'(n0), 64'd17);
            check($sformatf("v%0d_done_edge_lat2", i), 64'(n2), 64'd19);
            check($sformatf("v%0d_busy_at_e1", i), 64'(be1), 64'd1);
            check_order($sformatf("v%0d_vector_order", i));
            check($sformatf("v%0d_table", i), 64'(bus0.table_out), 64'(tv[i].tbl));
            check($sformatf("v%0d_err_cnt", i), 64'(bus0.err_cnt), 64'(tv[i].err));
            check($sformatf("v%0d_first_idx", i), 64'(bus0.first_err_idx), 64'(tv[i].fidx));
            check($sformatf("v%0d_first_valid", i), 64'(bus0.first_err_valid), 64'(tv[i].fval));
            check($sformatf("v%0d_pass", i), 64'(bus0.pass), 64'(tv[i].pass));
            check($sformatf("v%0d_idle_flags", i), {61'd0, bus0.busy, bus0.vec_valid, vec0 != 4'd0}, 64'd0);
            check($sformatf("v%0d_lat2_table", i), 64'(bus2.table_out), 64'(GOLD));
            check($sformatf("v%0d_lat2_pass", i), 64'(bus2.pass), 64'd1);
        end

        // Two-cycle-late f into the LAT=0 instance must be graded as wrong.
        mode = 5;
        run_sweep(-1, n0, n2, be1);
        check("lat0_delayed_done_edge", 64'(n0), 64'd17);
        check("lat0_delayed_err_nonzero", 64'(bus0.err_cnt != 5'd0), 64'd1);
        check("lat0_delayed_pass", 64'(bus0.pass), 64'd0);
        check("lat2_delayed_pass", 64'(bus2.pass), 64'd1);

        // start mid-sweep is ignored.
        mode = 0;
        run_sweep(5, n0, n2, be1);
        check("midstart_done_edge", 64'(n0), 64'd17);
        check_order("midstart_vector_order");
        check("midstart_pass", 64'(bus0.pass), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("midstart_done_held", {62'd0, bus0.done, bus0.busy}, 64'd2);

        // Reset at vector 8 aborts; a fresh start sweeps from 0.
        begin
            int   n;
            logic found;
            found = 1'b0;
            @(negedge clk) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n = 0;
            while (!found && n < 40) begin
                @(posedge clk);
                n++;
                #1;
                if (bus0.vec_valid && vec0 == 4'd8) found = 1'b1;
            end
            check("abort_reached_vec8", 64'(found), 64'd1);
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            check("abort_outputs_lat0", outs(0), 64'd0);
            check("abort_outputs_lat2", outs(2), 64'd0);
        end
        run_sweep(-1, n0, n2, be1);
        check("after_abort_done_edge", 64'(n0), 64'd17);
        check_order("after_abort_vector_order");
        check("after_abort_table", 64'(bus0.table_out), 64'(GOLD));
        check("after_abort_pass", 64'(bus0.pass), 64'd1);
        check("after_abort_lat2_pass", 64'(bus2.pass), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
